// File: rtl/eta_add_sched_if.sv
// Operand/result handshake bundle for the ETA adder sequencer.
interface eta_add_sched_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic             out_approx;
  logic             out_detect;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_approx, out_detect
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_approx, out_detect
  );
endinterface

// File: rtl/eta_add_sched.sv
// Sequencing controller around an error-tolerant adder: single-cycle
// approximate sum, iterative slice-wide exact sum, or auto-correction,
// plus saturating statistics on approximation events.
module eta_add_sched #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned APPROX_BITS = 20,
  parameter int unsigned SLICE       = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  eta_add_sched_if.slave   bus,
  input  logic             clr_stats,
  output logic             busy,
  output logic [CNT_W-1:0] stat_ops,
  output logic [CNT_W-1:0] stat_detect,
  output logic [CNT_W-1:0] stat_fixed
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned HI_W   = WIDTH - APPROX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_CORRECT,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             approx_q, approx_d;
  logic             detect_q, detect_d;
  logic             fixed_q, fixed_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] ops_q, ops_d;
  logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
  logic [CNT_W-1:0] fix_cnt_q, fix_cnt_d;

  logic [APPROX_BITS-1:0] gen;
  logic [APPROX_BITS-1:0] ctl;
  logic [HI_W:0]          hi_sum;
  logic [WIDTH:0]         eta_sum;
  logic                   detect;
  logic [SLICE:0]         slice_sum;
  logic                   retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ETA datapath on the latched operands plus the one-slice ripple adder.
  always_comb begin
    gen = a_q[APPROX_BITS-1:0] & b_q[APPROX_BITS-1:0];
    ctl = '0;
    ctl[APPROX_BITS-1] = gen[APPROX_BITS-1];
    // Suffix-OR from the top of the low segment downwards.
    for (int unsigned i = 1; i < APPROX_BITS; i++) begin
      ctl[APPROX_BITS-1-i] = ctl[APPROX_BITS-i] | gen[APPROX_BITS-1-i];
    end
    hi_sum    = {1'b0, a_q[WIDTH-1:APPROX_BITS]} + {1'b0, b_q[WIDTH-1:APPROX_BITS]};
    eta_sum   = {hi_sum, ctl | (a_q[APPROX_BITS-1:0] ^ b_q[APPROX_BITS-1:0])};
    detect    = |gen;
    slice_sum = {1'b0, a_q[k_q*SLICE +: SLICE]} + {1'b0, b_q[k_q*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry_q};
  end

  // Next-state, datapath register updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    mode_d       = mode_q;
    sum_d        = sum_q;
    approx_d     = approx_q;
    detect_d     = detect_q;
    fixed_d      = fixed_q;
    carry_d      = carry_q;
    k_d          = k_q;
    bus.in_ready = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          mode_d  = bus.in_mode;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        detect_d = detect;
        if (mode_q == 2'd0 || (mode_q == 2'd2 && !detect)) begin
          sum_d    = eta_sum;
          approx_d = detect;
          fixed_d  = 1'b0;
          state_d  = S_HOLD;
        end else begin
          carry_d = 1'b0;
          k_d     = '0;
          fixed_d = 1'b1;
          state_d = S_CORRECT;
        end
      end
      S_CORRECT: begin
        sum_d[k_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        carry_d = slice_sum[SLICE];
        k_d     = k_q + 1'b1;
        if (k_q == KW'(NSLICE - 1)) begin
          sum_d[WIDTH] = slice_sum[SLICE];
          approx_d     = 1'b0;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        bus.in_ready = bus.out_ready;
        if (bus.out_ready) begin
          retire = 1'b1;
          if (bus.in_valid) begin
            a_d     = bus.in_a;
            b_d     = bus.in_b;
            mode_d  = bus.in_mode;
            state_d = S_EVAL;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Statistics: bump on retirement, clear wins over a same-cycle bump.
  always_comb begin
    ops_d     = ops_q;
    det_cnt_d = det_cnt_q;
    fix_cnt_d = fix_cnt_q;
    if (clr_stats) begin
      ops_d     = '0;
      det_cnt_d = '0;
      fix_cnt_d = '0;
    end else if (retire) begin
      ops_d = sat_inc(ops_q);
      if (detect_q) det_cnt_d = sat_inc(det_cnt_q);
      if (fixed_q)  fix_cnt_d = sat_inc(fix_cnt_q);
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      sum_q     <= '0;
      approx_q  <= 1'b0;
      detect_q  <= 1'b0;
      fixed_q   <= 1'b0;
      carry_q   <= 1'b0;
      k_q       <= '0;
      ops_q     <= '0;
      det_cnt_q <= '0;
      fix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mode_q    <= mode_d;
      sum_q     <= sum_d;
      approx_q  <= approx_d;
      detect_q  <= detect_d;
      fixed_q   <= fixed_d;
      carry_q   <= carry_d;
      k_q       <= k_d;
      ops_q     <= ops_d;
      det_cnt_q <= det_cnt_d;
      fix_cnt_q <= fix_cnt_d;
    end
  end

  assign bus.out_valid  = (state_q == S_HOLD);
  assign bus.out_sum    = sum_q;
  assign bus.out_approx = approx_q;
  assign bus.out_detect = detect_q;
  assign busy           = (state_q != S_IDLE);
  assign stat_ops       = ops_q;
  assign stat_detect    = det_cnt_q;
  assign stat_fixed     = fix_cnt_q;

endmodule

// File: doc/eta_add_sched.md
Name: eta_add_sched

Overview:
- Sequencing controller around a 32-bit error-tolerant adder (ETA): upper bits exact ripple-carry, lower bits carry-free approximate.
- Accepts operand pairs over a valid/ready handshake and returns the single-cycle approximate sum, an exact sum, or an auto-corrected sum depending on a per-operation mode.
- Exact results come from an iterative SLICE-wide ripple-carry pass, one slice per cycle.
- Keeps saturating statistics on approximation events for the accuracy-evaluation flow.

Parameters:
WIDTH, 32, operand width; sum is WIDTH+1 bits.
APPROX_BITS, 20, width of the carry-free low segment; must be < WIDTH.
SLICE, 4, bits added per correction cycle; WIDTH % SLICE == 0.
CNT_W, 16, width of statistics counters.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_mode  in  2  0 = approx, 1 = exact, 2 = auto-correct, 3 = reserved (treated as exact)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_sum  out  WIDTH+1  result including carry-out
out_approx  out  1  out_sum is the ETA value and detect was 1, so it may be inexact
out_detect  out  1  low segment had at least one generate
busy  out  1  state != IDLE
clr_stats  in  1  synchronous clear of statistics counters
stat_ops  out  CNT_W  completed operations, saturating
stat_detect  out  CNT_W  operations with detect = 1, saturating
stat_fixed  out  CNT_W  operations that ran a correction pass, saturating

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-low, on `rst_n`; it is sampled only on the rising edge of `clk`.
- Reset values: state IDLE; out_valid, out_sum, out_approx, out_detect, busy and all stat_* are 0. in_ready is 1 after reset.
- Reset mid-operation: abandons any correction pass and drops a held result without asserting out_valid.
- ETA function (combinational, on the latched operands):
  - Low segment, bits APPROX_BITS-1 down to 0: g[i] = a[i] & b[i]; ctl[i] = OR of g[j] for j = i..APPROX_BITS-1.
  - sum[i] = 1 if ctl[i], else a[i] ^ b[i].
  - High segment: exact add of bits WIDTH-1..APPROX_BITS with carry-in 0, giving bits WIDTH..APPROX_BITS.
  - detect = |g over the low segment. When detect = 0 the ETA value is exact.
- States: IDLE, EVAL, CORRECT, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch a, b and mode, then go to EVAL.
- EVAL (1 cycle):
  - Compute detect.
  - If mode = approx, or mode = auto with detect = 0: load out_sum with the ETA value, set out_approx = detect, go to HOLD.
  - Otherwise: clear the carry register and the slice index k, then go to CORRECT.
- CORRECT:
  - Each cycle adds slice k with the carry register, writes result bits [k*SLICE +: SLICE] and updates the carry.
  - After slice WIDTH/SLICE-1, write bit WIDTH = carry, set out_approx = 0, go to HOLD.
  - Takes exactly WIDTH/SLICE cycles (8 at defaults).
- HOLD:
  - out_valid = 1; out_sum, out_approx and out_detect are stable while out_valid=1 && !out_ready.
  - On out_ready: the result retires and stats update.
  - If in_valid is also high in that cycle, new operands are latched and the state goes to EVAL; otherwise it goes to IDLE.
  - in_ready = out_ready in HOLD; in_ready = 0 in EVAL and CORRECT.
- Latency, accept at edge T:
  - Approx path: out_valid from T+2.
  - Correction path: out_valid from T+2+WIDTH/SLICE, i.e. T+10 at defaults.
- Stats, updated at retirement only:
  - stat_ops +1 always; stat_detect +1 if detect; stat_fixed +1 if a CORRECT pass ran.
  - Each counter saturates at all-ones and does not wrap.
  - clr_stats has priority over a same-cycle increment; the counters read 0 next cycle.
- Mode is latched at accept; changes on in_mode at any other time have no effect.

Test Plan:
1. a=0x00000001, b=0x00000001, mode=0 -> out_sum=0x000000001, detect=1, approx=1, out_valid at T+2. Same operands with mode=2 -> out_sum=0x000000002, approx=0, out_valid at T+10.
2. a=0x00080000, b=0x00080000, mode=0 -> out_sum=0x0000FFFFF, detect=1. Same operands with mode=1 -> out_sum=0x000100000.
3. a=0x12340000, b=0x00010000, mode=2 -> detect=0, out_sum=0x012350000 at T+2, stat_fixed unchanged.
4. a=b=0xFFFFFFFF, mode=1 -> out_sum=0x1FFFFFFFE, approx=0; stat_ops=1, stat_fixed=1, stat_detect=1.
5. Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_sum stable, in_ready=0. Raise out_ready together with in_valid -> back-to-back accept, next result correct.
6. Assert rst_n=0 during CORRECT cycle 4 -> next cycle out_valid=0, busy=0, in_ready=1. Preload stats to 0xFFFF -> they saturate on retire; clr_stats -> 0.
